cim_cmd_scheduler: RTL

- Sequences a queued stream of load-store and compute commands onto one MUL_controller.
- Buffers host commands in a small FIFO.
- Issues ExLdSt one-cycle commands and Compute valid/ready transactions, holding multi-cycle MUL commands stable until accepted.
- Serialises the two channels so an external load-store never overlaps an in-flight compute.

---
 rtl/cim_sched_pkg.sv | 30 +++
 rtl/cim_cmd_scheduler_if.sv | 31 +++
 rtl/cim_cmd_fifo.sv | 52 +++++
 rtl/cim_cmd_scheduler.sv | 109 ++++++++++
 4 files changed

// File: rtl/cim_sched_pkg.sv
// Shared field positions, compute mode codes and scheduler state encoding
// for the CIM command scheduler.
package cim_sched_pkg;

   localparam int unsigned CMD_W       = 25;
   localparam int unsigned ENTRY_W     = CMD_W + 1;
   localparam int unsigned CMD_SPECIAL = 24;
   localparam int unsigned MODE_HI     = 23;
   localparam int unsigned MODE_LO     = 21;
   localparam int unsigned LEN_HI      = 20;
   localparam int unsigned LEN_LO      = 18;
   localparam int unsigned LDST_WR     = 6;
   localparam int unsigned ADDR_W      = 6;

   localparam logic [2:0] MODE_NOP   = 3'b000;
   localparam logic [2:0] MODE_COPY  = 3'b001;
   localparam logic [2:0] MODE_AND   = 3'b010;
   localparam logic [2:0] MODE_XOR   = 3'b011;
   localparam logic [2:0] MODE_SHIFT = 3'b100;
   localparam logic [2:0] MODE_ADD   = 3'b101;
   localparam logic [2:0] MODE_SUB   = 3'b110;
   localparam logic [2:0] MODE_MUL   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      LDST = 2'd2
   } state_e;

endpackage

// File: rtl/cim_cmd_scheduler_if.sv
// Host command channel plus the ExLdSt / Compute channels towards the
// MUL_controller; master is the environment side, slave is the scheduler.
interface cim_cmd_scheduler_if #(
   parameter int unsigned CNT_W = 16
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_type;
   logic [24:0]      cmd_payload;
   logic             ExLdSt_valid;
   logic [6:0]       ExLdSt_command;
   logic             ldst_rd_strobe;
   logic             Compute_valid;
   logic [24:0]      Compute_command;
   logic             Compute_ready;
   logic             busy;
   logic             nop_drop;
   logic [CNT_W-1:0] issued_cnt;

   modport master (
      output cmd_valid, cmd_type, cmd_payload, Compute_ready,
      input  cmd_ready, ExLdSt_valid, ExLdSt_command, ldst_rd_strobe, Compute_valid,
      input  Compute_command, busy, nop_drop, issued_cnt
   );

   modport slave (
      input  cmd_valid, cmd_type, cmd_payload, Compute_ready,
      output cmd_ready, ExLdSt_valid, ExLdSt_command, ldst_rd_strobe, Compute_valid,
      output Compute_command, busy, nop_drop, issued_cnt
   );
endinterface

// File: rtl/cim_cmd_fifo.sv
// Synchronous DEPTH-entry command FIFO; a push into a full FIFO is refused
// even if a pop happens in the same cycle.
module cim_cmd_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 26,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [PTR_W:0]   count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_q, rd_q;
   logic [PTR_W:0]   cnt_q;
   logic             do_push, do_pop;

   assign full    = (cnt_q == (PTR_W+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign count   = cnt_q;
   assign rdata   = mem[rd_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_q] <= wdata;
   end

   // Pointers are PTR_W wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/cim_cmd_scheduler.sv
// Pops queued host commands and issues them either as ExLdSt strobes or as
// held Compute transactions, never overlapping the two channels.
module cim_cmd_scheduler
   import cim_sched_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 16
) (
   input logic                 clk,
   input logic                 rst,
   cim_cmd_scheduler_if.slave  bus
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   state_e             state_q, state_d;
   logic               cv_q, cv_d;
   logic [CMD_W-1:0]   cc_q, cc_d;
   logic               lv_q, lv_d;
   logic [ADDR_W:0]    lc_q, lc_d;
   logic               nop_q, nop_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               pop, full, empty, free;
   logic [ENTRY_W-1:0] head;
   logic [PTR_W:0]     count;
   logic [2:0]         head_mode;

   cim_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (bus.cmd_valid),
      .pop   (pop),
      .wdata ({bus.cmd_type, bus.cmd_payload}),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign head_mode = head[MODE_HI:MODE_LO];
   // Any non-CMP encoding counts as free so a corrupted state cannot deadlock.
   assign free      = (state_q != CMP) | bus.Compute_ready;

   always_comb begin
      state_d = state_q;
      cv_d    = cv_q;
      cc_d    = cc_q;
      lv_d    = 1'b0;
      lc_d    = lc_q;
      nop_d   = 1'b0;
      cnt_d   = cnt_q;
      pop     = 1'b0;
      if (free) begin
         cv_d    = 1'b0;
         state_d = IDLE;
         if (!empty) begin
            pop = 1'b1;
            if (head[ENTRY_W-1]) begin
               lv_d    = 1'b1;
               lc_d    = head[ADDR_W:0];
               state_d = LDST;
               cnt_d   = cnt_q + 1'b1;
            end else if (head_mode == MODE_NOP) begin
               nop_d = 1'b1;
            end else begin
               cv_d    = 1'b1;
               cc_d    = head[CMD_W-1:0];
               state_d = CMP;
               cnt_d   = cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cv_q    <= 1'b0;
         cc_q    <= '0;
         lv_q    <= 1'b0;
         lc_q    <= '0;
         nop_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cv_q    <= cv_d;
         cc_q    <= cc_d;
         lv_q    <= lv_d;
         lc_q    <= lc_d;
         nop_q   <= nop_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.cmd_ready       = ~full;
   assign bus.ExLdSt_valid    = lv_q;
   assign bus.ExLdSt_command  = lc_q;
   assign bus.ldst_rd_strobe  = lv_q & ~lc_q[LDST_WR];
   assign bus.Compute_valid   = cv_q;
   assign bus.Compute_command = cc_q;
   assign bus.busy            = ~empty | cv_q | lv_q;
   assign bus.nop_drop        = nop_q;
   assign bus.issued_cnt      = cnt_q;

endmodule
